// File: rtl/mdr_iterative_unit_pkg.sv
// Shared types and defaults for the iterative multiply / divide / square-root unit.
package mdr_iterative_unit_pkg;

  typedef enum logic [1:0] {
    OpMult = 2'b00,
    OpDiv  = 2'b01,
    OpRoot = 2'b10,
    OpRsvd = 2'b11
  } op_select_t;

  typedef enum logic [2:0] {
    StIdle,
    StLoadX,
    StLoadY,
    StCheck,
    StRun,
    StDone,
    StError
  } mdr_state_e;

  localparam int unsigned MdrDefaultDw = 16;
  localparam int unsigned MdrDefaultCw = $clog2(MdrDefaultDw) + 1;

endpackage

// File: rtl/mdr_iterative_unit_addsub.sv
// Combinational W-bit adder/subtractor shared by all iterative algorithms.
module mdr_iterative_unit_addsub #(
  parameter int unsigned W = 18
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         sub_i,
  output logic [W-1:0] sum_o,
  output logic         borrow_o
);

  logic [W:0] full;

  assign full     = {1'b0, a_i} + {1'b0, (sub_i ? ~b_i : b_i)} + {{W{1'b0}}, sub_i};
  assign sum_o    = full[W-1:0];
  // Carry-out on add; inverted carry is the borrow on subtract.
  assign borrow_o = sub_i ? ~full[W] : full[W];

endmodule

// File: rtl/mdr_iterative_unit.sv
// Radix-2 multi-cycle multiply / restoring divide / restoring square root over one add/sub,
// with serial operand loading, optional signed mode and a sticky error flag.
module mdr_iterative_unit
  import mdr_iterative_unit_pkg::*;
#(
  parameter int unsigned DW        = MdrDefaultDw,
  parameter bit          SIGNED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_start,
  input  logic            i_load,
  input  logic [DW-1:0]   i_data,
  input  logic [1:0]      i_op,
  input  logic            i_signed,
  output logic            o_load_x,
  output logic            o_load_y,
  output logic            o_busy,
  output logic            o_ready,
  output logic            o_error,
  output logic [2*DW-1:0] o_result,
  output logic [DW-1:0]   o_remainder
);

  localparam int unsigned CW = $clog2(DW) + 1;
  localparam int unsigned AW = DW + 2;
  localparam int unsigned HW = DW / 2;

  mdr_state_e      state_q, state_d;
  op_select_t      op_q, op_d;
  logic            signed_q, signed_d, sx_q, sx_d, sy_q, sy_d, error_q, error_d;
  logic [DW-1:0]   x_q, x_d, y_q, y_d, rmd_q, rmd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*DW-1:0] acc_q, acc_d, res_q, res_d;
  logic [DW:0]     rem_q, rem_d, rem_sh;

  logic [AW-1:0]   add_a, add_b, add_sum;
  logic            add_sub, add_borrow, trial_neg, unused_bits;
  logic            x_neg, y_neg, res_neg;
  logic [DW-1:0]   x_mag, y_mag, rmd_fin;
  logic [2*DW-1:0] res_mag, res_fin;

  // -2^(DW-1) maps onto 2^(DW-1) when read back as unsigned.
  assign x_neg = signed_q & x_q[DW-1];
  assign y_neg = signed_q & y_q[DW-1];
  assign x_mag = x_neg ? -x_q : x_q;
  assign y_mag = y_neg ? -y_q : y_q;

  assign rem_sh      = {rem_q[DW-1:0], acc_q[DW-1]};
  assign trial_neg   = add_sum[AW-1];
  assign unused_bits = add_borrow ^ rem_q[DW];

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b1;
    case (op_q)
      OpMult: begin
        add_a   = {2'b00, acc_q[2*DW-1:DW]};
        add_b   = {2'b00, x_q};
        add_sub = 1'b0;
      end
      OpDiv: begin
        add_a = {1'b0, rem_sh};
        add_b = {2'b00, y_q};
      end
      default: begin
        add_a = {rem_q[DW-1:0], acc_q[DW-1:DW-2]};
        add_b = {{HW{1'b0}}, acc_q[DW +: HW], 2'b01};
      end
    endcase
  end

  mdr_iterative_unit_addsub #(
    .W(AW)
  ) u_addsub (
    .a_i     (add_a),
    .b_i     (add_b),
    .sub_i   (add_sub),
    .sum_o   (add_sum),
    .borrow_o(add_borrow)
  );

  always_comb begin
    case (op_q)
      OpDiv:   res_mag = {{DW{1'b0}}, acc_q[DW-1:0]};
      OpRoot:  res_mag = {{(2*DW-HW){1'b0}}, acc_q[DW +: HW]};
      default: res_mag = acc_q;
    endcase
    res_neg = (op_q != OpRoot) & (sx_q ^ sy_q);
    res_fin = res_neg ? -res_mag : res_mag;
    if (op_q == OpMult) begin
      rmd_fin = '0;
    end else if (op_q == OpDiv && sx_q) begin
      rmd_fin = -rem_q[DW-1:0];
    end else begin
      rmd_fin = rem_q[DW-1:0];
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    signed_d = signed_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    error_d  = error_q;
    x_d      = x_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    res_d    = res_q;
    rmd_d    = rmd_q;
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          op_d     = op_select_t'(i_op);
          signed_d = i_signed & SIGNED_EN;
          error_d  = 1'b0;
          res_d    = '0;
          rmd_d    = '0;
          state_d  = StLoadX;
        end
      end
      StLoadX: begin
        if (i_load) begin
          x_d     = i_data;
          state_d = (op_q == OpRoot) ? StCheck : StLoadY;
        end
      end
      StLoadY: begin
        if (i_load) begin
          y_d     = i_data;
          state_d = StCheck;
        end
      end
      StCheck: begin
        if (op_q == OpRsvd || (op_q == OpDiv && y_q == '0) || (op_q == OpRoot && x_neg)) begin
          state_d = StError;
        end else begin
          sx_d    = x_neg;
          sy_d    = (op_q != OpRoot) & y_neg;
          x_d     = x_mag;
          y_d     = y_mag;
          rem_d   = '0;
          acc_d   = {{DW{1'b0}}, ((op_q == OpMult) ? y_mag : x_mag)};
          cnt_d   = (op_q == OpRoot) ? CW'(HW) : CW'(DW);
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = cnt_q - CW'(1);
        case (op_q)
          OpMult: begin
            acc_d = acc_q[0] ? {add_sum[DW:0], acc_q[DW-1:1]} : {1'b0, acc_q[2*DW-1:1]};
          end
          OpDiv: begin
            rem_d          = trial_neg ? rem_sh : add_sum[DW:0];
            acc_d[DW-1:0]  = {acc_q[DW-2:0], ~trial_neg};
          end
          default: begin
            rem_d           = trial_neg ? {rem_q[DW-2:0], acc_q[DW-1:DW-2]} : add_sum[DW:0];
            acc_d[DW-1:0]   = {acc_q[DW-3:0], 2'b00};
            acc_d[DW +: HW] = {acc_q[DW +: (HW-1)], ~trial_neg};
          end
        endcase
        if (cnt_q == CW'(1)) begin
          state_d = StDone;
        end
      end
      StDone: begin
        res_d   = res_fin;
        rmd_d   = rmd_fin;
        state_d = StIdle;
      end
      StError: begin
        error_d = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      op_q     <= OpMult;
      signed_q <= 1'b0;
      sx_q     <= 1'b0;
      sy_q     <= 1'b0;
      error_q  <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      res_q    <= '0;
      rmd_q    <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      signed_q <= signed_d;
      sx_q     <= sx_d;
      sy_q     <= sy_d;
      error_q  <= error_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      res_q    <= res_d;
      rmd_q    <= rmd_d;
    end
  end

  // Results are shown during the done strobe and held in the result registers afterwards.
  assign o_load_x    = (state_q == StLoadX);
  assign o_load_y    = (state_q == StLoadY);
  assign o_busy      = (state_q != StIdle);
  assign o_ready     = (state_q == StDone) || (state_q == StError);
  assign o_error     = error_q || (state_q == StError);
  assign o_result    = (state_q == StDone) ? res_fin : res_q;
  assign o_remainder = (state_q == StDone) ? rmd_fin : rmd_q;

endmodule

// File: tb/tb_mdr_iterative_unit.sv
// Directed plus model-based bench for mdr_iterative_unit with a result scoreboard.
module tb_mdr_iterative_unit;
  import mdr_iterative_unit_pkg::*;

  localparam int unsigned DW = MdrDefaultDw;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_start = 1'b0;
  logic            i_load = 1'b0;
  logic [DW-1:0]   i_data = '0;
  logic [1:0]      i_op = 2'b00;
  logic            i_signed = 1'b0;
  logic            o_load_x, o_load_y, o_busy, o_ready, o_error;
  logic [2*DW-1:0] o_result;
  logic [DW-1:0]   o_remainder;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    string           tag;
    logic [2*DW-1:0] res;
    logic [DW-1:0]   rmd;
    logic            err;
    int              lat;
  } exp_t;

  exp_t sb[$];

  mdr_iterative_unit #(
    .DW       (DW),
    .SIGNED_EN(1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .i_start    (i_start),
    .i_load     (i_load),
    .i_data     (i_data),
    .i_op       (i_op),
    .i_signed   (i_signed),
    .o_load_x   (o_load_x),
    .o_load_y   (o_load_y),
    .o_busy     (o_busy),
    .o_ready    (o_ready),
    .o_error    (o_error),
    .o_result   (o_result),
    .o_remainder(o_remainder)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference arithmetic on native 64-bit integers.
  task automatic model(input logic [1:0] op, input logic sgn, input logic [DW-1:0] x,
                       input logic [DW-1:0] y, output logic [2*DW-1:0] res,
                       output logic [DW-1:0] rmd, output logic err);
    longint a, b, p, r;
    a   = sgn ? longint'($signed(x)) : longint'(x);
    b   = sgn ? longint'($signed(y)) : longint'(y);
    res = '0;
    rmd = '0;
    err = 1'b0;
    case (op)
      2'b00: begin
        p   = a * b;
        res = p[2*DW-1:0];
      end
      2'b01: begin
        if (b == 0) begin
          err = 1'b1;
        end else begin
          p   = a / b;
          r   = a % b;
          res = p[2*DW-1:0];
          rmd = r[DW-1:0];
        end
      end
      2'b10: begin
        if (a < 0) begin
          err = 1'b1;
        end else begin
          r = 0;
          while ((r + 1) * (r + 1) <= a) r++;
          p   = a - r * r;
          res = r[2*DW-1:0];
          rmd = p[DW-1:0];
        end
      end
      default: err = 1'b1;
    endcase
  endtask

  task automatic run_op(input string tag, input logic [1:0] op, input logic sgn,
                        input logic [DW-1:0] x, input logic [DW-1:0] y,
                        input logic [2*DW-1:0] er, input logic [DW-1:0] em, input logic ee,
                        input logic clash);
    exp_t e, got;
    int   lat;
    logic saw_y;
    @(negedge clk);
    i_start  = 1'b1;
    i_op     = op;
    i_signed = sgn;
    if (clash) begin
      i_load = 1'b1;
      i_data = ~x;
    end
    @(negedge clk);
    i_start  = 1'b0;
    i_load   = 1'b0;
    i_op     = ~op;
    i_signed = ~sgn;
    check({tag, " start"}, {o_busy, o_load_x, o_error, (o_result == '0), (o_remainder == '0)},
          5'b11011);
    @(negedge clk);
    i_load = 1'b1;
    i_data = x;
    if (op != 2'b10) begin
      @(negedge clk);
      i_load = 1'b0;
      check({tag, " load_y"}, {o_load_x, o_load_y}, 2'b01);
      @(negedge clk);
      i_load = 1'b1;
      i_data = y;
    end
    e.tag = tag;
    e.res = er;
    e.rmd = em;
    e.err = ee;
    e.lat = ee ? 2 : ((op == 2'b10) ? (DW / 2 + 2) : (DW + 2));
    sb.push_back(e);
    @(negedge clk);
    i_load = 1'b0;
    lat    = 1;
    saw_y  = 1'b0;
    while (!o_ready && lat < 64) begin
      saw_y   = saw_y | o_load_y;
      i_start = (lat == 4);
      @(negedge clk);
      lat++;
    end
    i_start = 1'b0;
    got = sb.pop_front();
    check({got.tag, " ready"}, o_ready, 1'b1);
    check({got.tag, " latency"}, lat, got.lat);
    check({got.tag, " result"}, o_result, got.res);
    check({got.tag, " remainder"}, o_remainder, got.rmd);
    check({got.tag, " error"}, o_error, got.err);
    check({got.tag, " no_load_y"}, saw_y, 1'b0);
    @(negedge clk);
    check({got.tag, " hold"}, {o_ready, o_busy, o_error, o_result, o_remainder},
          {2'b00, got.err, got.res, got.rmd});
  endtask

  initial begin
    logic [1:0]      r_op;
    logic            r_sgn;
    logic [DW-1:0]   r_x, r_y, m_rmd;
    logic [2*DW-1:0] m_res;
    logic            m_err;

    repeat (3) @(negedge clk);
    check("reset", {o_busy, o_ready, o_load_x, o_load_y, o_error, o_result, o_remainder}, '0);
    rst = 1'b1;

    run_op("mul_u", 2'b00, 1'b0, 16'd300, 16'd200, 32'h0000EA60, 16'h0000, 1'b0, 1'b0);
    run_op("mul_s", 2'b00, 1'b1, 16'hFFF9, 16'd3, 32'hFFFFFFEB, 16'h0000, 1'b0, 1'b1);
    run_op("mul_min", 2'b00, 1'b1, 16'h8000, 16'h8000, 32'h40000000, 16'h0000, 1'b0, 1'b0);
    run_op("div_u", 2'b01, 1'b0, 16'd100, 16'd7, 32'd14, 16'd2, 1'b0, 1'b0);
    run_op("div_s", 2'b01, 1'b1, 16'hFF9C, 16'd7, 32'hFFFFFFF2, 16'hFFFE, 1'b0, 1'b0);
    run_op("div_min", 2'b01, 1'b1, 16'h8000, 16'hFFFF, 32'h00008000, 16'h0000, 1'b0, 1'b0);
    run_op("div_u_top", 2'b01, 1'b0, 16'h8000, 16'd3, 32'd10922, 16'd2, 1'b0, 1'b0);
    run_op("div_zero", 2'b01, 1'b0, 16'd5, 16'd0, 32'd0, 16'd0, 1'b1, 1'b0);
    run_op("mul_zero", 2'b00, 1'b0, 16'd0, 16'd1234, 32'd0, 16'd0, 1'b0, 1'b0);
    run_op("root", 2'b10, 1'b0, 16'd1000, 16'd0, 32'd31, 16'd39, 1'b0, 1'b0);
    run_op("root_max", 2'b10, 1'b0, 16'hFFFF, 16'd0, 32'd255, 16'd510, 1'b0, 1'b0);
    run_op("root_zero", 2'b10, 1'b1, 16'd0, 16'd0, 32'd0, 16'd0, 1'b0, 1'b0);
    run_op("root_neg", 2'b10, 1'b1, 16'hFFF0, 16'd0, 32'd0, 16'd0, 1'b1, 1'b0);
    run_op("rsvd", 2'b11, 1'b0, 16'd1, 16'd2, 32'd0, 16'd0, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      r_op  = 2'($urandom_range(0, 2));
      r_sgn = 1'($urandom_range(0, 1));
      r_x   = DW'($urandom);
      r_y   = DW'($urandom);
      model(r_op, r_sgn, r_x, r_y, m_res, m_rmd, m_err);
      run_op($sformatf("rand%0d", i), r_op, r_sgn, r_x, r_y, m_res, m_rmd, m_err, 1'b0);
    end

    // Abort a multiply mid-iteration with an asynchronous reset.
    @(negedge clk);
    i_start = 1'b1;
    i_op    = 2'b00;
    i_signed = 1'b0;
    @(negedge clk);
    i_start = 1'b0;
    i_load  = 1'b1;
    i_data  = 16'd9;
    @(negedge clk);
    i_data = 16'd11;
    @(negedge clk);
    i_load = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_busy", o_busy, 1'b1);
    rst = 1'b0;
    #1;
    check("mid_reset", {o_busy, o_ready, o_load_x, o_load_y, o_error, o_result, o_remainder}, '0);
    @(negedge clk);
    rst = 1'b1;

    run_op("mul_post_rst", 2'b00, 1'b0, 16'd3, 16'd4, 32'd12, 16'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
